aib_link_bringup_seq: RTL and testbench
=======================================

Name: aib_link_bringup_seq

Overview:
Single-channel AIB Gen2 link bring-up sequencer for the AXI leader bridge, clocked in the clk_wr domain.
- Waits for far-side device detect.
- Programs the AIB channel CSRs through the AVMM config port from an external table.
- Releases the adapter reset, raises MAC-ready and the DCC/DLL lock requests, then waits for transfer-enable and RX alignment.
- Gates tx_online/rx_online to the AXI-MM master, supervises the link and retries on loss or timeout.

Parameters:
CFG_DEPTH, 8, number of AVMM writes in the config table (1..64)
TIMEOUT_CYC, 65535, max cycles waiting for lock/align before retry
SETTLE_CYC, 16, cycles between reset release and lock requests
MAX_RETRY, 3, retries before sticky failure
AVMM_WIDTH, 32, AVMM data width
BYTE_WIDTH, 4, AVMM byte-enable width

Ports:
clk_wr  in  1  sequencer clock; AVMM config port also runs on this clock
rst_wr  in  1  synchronous active-high reset
start  in  1  level; bring-up enabled while high
m_device_detect  in  1  far-side device present
cfg_idx  out  6  table index being fetched
cfg_addr  in  17  table address for cfg_idx (combinational ROM)
cfg_wdata  in  AVMM_WIDTH  table data for cfg_idx
avmm_addr  out  17  AVMM address
avmm_byte_en  out  BYTE_WIDTH  AVMM byte enables, all ones when writing
avmm_write  out  1  AVMM write request
avmm_wdata  out  AVMM_WIDTH  AVMM write data
avmm_waitreq  in  1  AVMM wait request
ns_adapter_rstn  out  1  adapter reset, active low
ns_mac_rdy  out  1  near-side MAC ready
dcc_dll_lock_req  out  4  {ms_rx, ms_tx, sl_rx, sl_tx} lock requests
ms_tx_transfer_en  in  1  leader TX enabled
sl_tx_transfer_en  in  1  follower TX enabled
m_rx_align_done  in  1  RX word alignment done
fs_mac_rdy  in  1  far-side MAC ready
tx_online  out  1  AXI master TX enable
rx_online  out  1  AXI master RX enable
link_up  out  1  link operational
link_fail  out  1  sticky failure flag
retry_cnt  out  2  retries consumed

Behaviour:
- Reset values: all outputs 0, except ns_adapter_rstn=0, avmm_byte_en=0, and retry_cnt=0. Reset mid-sequence aborts immediately; avmm_write drops on the cycle after rst_wr is sampled.
- Inputs are already synchronous to clk_wr. The block adds no synchronizers.
- IDLE: go to DETECT when start=1.
- start=0 in any state except FAIL: next state IDLE, all outputs return to reset values, retry_cnt cleared.
- DETECT: wait for m_device_detect=1; then cfg_idx<=0 and go to CFG_ISSUE.
- CFG_ISSUE: on entry register cfg_addr/cfg_wdata, assert avmm_write and avmm_byte_en all ones.
  - Hold all AVMM outputs stable while avmm_waitreq=1.
  - Write completes in the first cycle with avmm_write=1 and avmm_waitreq=0.
  - Next cycle: avmm_write=0 (one idle gap between writes), cfg_idx increments.
  - After write CFG_DEPTH-1 completes, go to ADPT_RST.
- ADPT_RST: ns_adapter_rstn=1, ns_mac_rdy=1; count SETTLE_CYC cycles, then go to LOCK.
- LOCK: dcc_dll_lock_req=4'hF.
  - Go to LINK_UP when ms_tx_transfer_en & sl_tx_transfer_en & m_rx_align_done & fs_mac_rdy are all high in the same cycle.
  - Timeout counter is 16 bits and saturates. At count==TIMEOUT_CYC-1 without success, go to RETRY; success in that same cycle wins.
- LINK_UP: link_up, tx_online and rx_online go high the cycle after entry; lock requests stay asserted. Any of the four conditions dropping goes to RETRY next cycle.
- RETRY: one cycle.
  - Drop tx/rx_online, link_up, lock requests, ns_mac_rdy and ns_adapter_rstn.
  - If retry_cnt==MAX_RETRY go to FAIL; else retry_cnt++ and return to DETECT, re-running the CSR programming.
- FAIL: link_fail=1, all link outputs inactive; exit only by rst_wr.
- retry_cnt is never cleared by a successful link; only rst_wr or start=0 clear it.
- m_device_detect loss in any state from CFG_ISSUE through LINK_UP goes to RETRY, after completing an in-flight AVMM write.

Test Plan:
- CFG_DEPTH=3, waitreq=0, detect high, all link status high after 10 cycles post-SETTLE -> exactly 3 writes, addresses table[0..2], one idle cycle between; link_up=1 and tx_online=1 one cycle after LOCK success.
- waitreq held high 5 cycles on write 1 -> avmm_addr/wdata/write stable for 6 cycles; cfg_idx does not advance until release.
- m_rx_align_done never rises, TIMEOUT_CYC=100, MAX_RETRY=3 -> 3 retries, each re-running config; then link_fail=1, retry_cnt=3, sticky until rst_wr.
- Link up, then fs_mac_rdy drops 1 cycle -> tx_online=0 next cycle; retry_cnt=1; re-sequence completes with link_up=1 again.
- rst_wr asserted during CFG_ISSUE with waitreq high -> avmm_write=0 and ns_adapter_rstn=0 the next cycle; restart writes from cfg_idx=0.
- start deasserted in LINK_UP -> IDLE next cycle, all outputs at reset values, retry_cnt=0.

Source files
------------

// File: rtl/aib_link_bringup_seq_if.sv
// AVMM configuration write port between the AIB bring-up sequencer and the channel CSR block.
interface aib_link_bringup_seq_if #(
    parameter int AVMM_WIDTH = 32,
    parameter int BYTE_WIDTH = 4
);
    logic [16:0]           avmm_addr;
    logic [BYTE_WIDTH-1:0] avmm_byte_en;
    logic                  avmm_write;
    logic [AVMM_WIDTH-1:0] avmm_wdata;
    logic                  avmm_waitreq;

    // Handshake: a write is accepted at the first clk_wr edge with avmm_write=1 and avmm_waitreq=0;
    // until then the master holds avmm_addr/avmm_byte_en/avmm_wdata/avmm_write unchanged.
    modport master (
        output avmm_addr, avmm_byte_en, avmm_write, avmm_wdata,
        input  avmm_waitreq
    );
    modport slave (
        input  avmm_addr, avmm_byte_en, avmm_write, avmm_wdata,
        output avmm_waitreq
    );
endinterface

// File: rtl/aib_link_bringup_seq.sv
// Single-channel AIB Gen2 link bring-up sequencer: detect, CSR programming, adapter reset release,
// lock/alignment wait, online gating and retry supervision, all in the clk_wr domain.
module aib_link_bringup_seq #(
    parameter int CFG_DEPTH   = 8,
    parameter int TIMEOUT_CYC = 65535,
    parameter int SETTLE_CYC  = 16,
    parameter int MAX_RETRY   = 3,
    parameter int AVMM_WIDTH  = 32,
    parameter int BYTE_WIDTH  = 4
) (
    input  logic                   clk_wr,
    input  logic                   rst_wr,
    input  logic                   start,
    input  logic                   m_device_detect,
    output logic [5:0]             cfg_idx,
    input  logic [16:0]            cfg_addr,
    input  logic [AVMM_WIDTH-1:0]  cfg_wdata,
    aib_link_bringup_seq_if.master avmm,
    output logic                   ns_adapter_rstn,
    output logic                   ns_mac_rdy,
    output logic [3:0]             dcc_dll_lock_req,
    input  logic                   ms_tx_transfer_en,
    input  logic                   sl_tx_transfer_en,
    input  logic                   m_rx_align_done,
    input  logic                   fs_mac_rdy,
    output logic                   tx_online,
    output logic                   rx_online,
    output logic                   link_up,
    output logic                   link_fail,
    output logic [1:0]             retry_cnt,
    output logic [3:0]             state_dbg
);
    typedef enum logic [3:0] {
        S_IDLE, S_DETECT, S_CFG_ISSUE, S_CFG_GAP, S_ADPT_RST,
        S_LOCK, S_LINK_UP, S_RETRY, S_FAIL
    } state_t;

    localparam logic [5:0]  CFG_LAST     = 6'(CFG_DEPTH - 1);
    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [1:0]  RETRY_LIMIT  = 2'(MAX_RETRY);

    state_t      state, state_n;
    logic [15:0] cnt;
    logic        online;
    logic        link_ok;
    logic        wr_done;
    logic        load_wr;

    assign link_ok = ms_tx_transfer_en & sl_tx_transfer_en & m_rx_align_done & fs_mac_rdy;
    assign wr_done = (state == S_CFG_ISSUE) && !avmm.avmm_waitreq;
    assign load_wr = (state_n == S_CFG_ISSUE) && (state != S_CFG_ISSUE);

    always_ff @(posedge clk_wr) begin
        if (rst_wr) state <= S_IDLE;
        else        state <= state_n;
    end

    // Detect loss during programming waits for the in-flight write to be accepted.
    always_comb begin
        state_n = state;
        if (!start && state != S_FAIL) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:      state_n = S_DETECT;
                S_DETECT:    if (m_device_detect) state_n = S_CFG_ISSUE;
                S_CFG_ISSUE: begin
                    if (wr_done) begin
                        if (!m_device_detect)     state_n = S_RETRY;
                        else if (cfg_idx == CFG_LAST) state_n = S_ADPT_RST;
                        else                      state_n = S_CFG_GAP;
                    end
                end
                S_CFG_GAP:   state_n = m_device_detect ? S_CFG_ISSUE : S_RETRY;
                S_ADPT_RST: begin
                    if (!m_device_detect)         state_n = S_RETRY;
                    else if (cnt == SETTLE_LAST)  state_n = S_LOCK;
                end
                S_LOCK: begin
                    if (!m_device_detect)         state_n = S_RETRY;
                    else if (link_ok)             state_n = S_LINK_UP;
                    else if (cnt == TIMEOUT_LAST) state_n = S_RETRY;
                end
                S_LINK_UP:   if (!m_device_detect || !link_ok) state_n = S_RETRY;
                S_RETRY:     state_n = (retry_cnt == RETRY_LIMIT) ? S_FAIL : S_DETECT;
                S_FAIL:      state_n = S_FAIL;
                default:     state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr || state_n == S_IDLE) begin
            cnt               <= '0;
            online            <= 1'b0;
            cfg_idx           <= '0;
            retry_cnt         <= '0;
            avmm.avmm_addr    <= '0;
            avmm.avmm_wdata   <= '0;
            avmm.avmm_write   <= 1'b0;
            avmm.avmm_byte_en <= '0;
        end else begin
            if (state_n != state)    cnt <= '0;
            else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
            // Online follows LINK_UP by one cycle and drops on the edge that leaves it.
            online <= (state == S_LINK_UP) && (state_n == S_LINK_UP);
            if (state == S_RETRY || state == S_DETECT) cfg_idx <= '0;
            else if (wr_done)                          cfg_idx <= cfg_idx + 6'd1;
            if (state == S_RETRY && state_n == S_DETECT) retry_cnt <= retry_cnt + 2'd1;
            if (load_wr) begin
                avmm.avmm_addr    <= cfg_addr;
                avmm.avmm_wdata   <= cfg_wdata;
                avmm.avmm_write   <= 1'b1;
                avmm.avmm_byte_en <= '1;
            end else if (state_n != S_CFG_ISSUE) begin
                avmm.avmm_write   <= 1'b0;
                avmm.avmm_byte_en <= '0;
            end
        end
    end

    assign ns_adapter_rstn  = (state == S_ADPT_RST) || (state == S_LOCK) || (state == S_LINK_UP);
    assign ns_mac_rdy       = ns_adapter_rstn;
    assign dcc_dll_lock_req = ((state == S_LOCK) || (state == S_LINK_UP)) ? 4'hF : 4'h0;
    assign tx_online        = online;
    assign rx_online        = online;
    assign link_up          = online;
    assign link_fail        = (state == S_FAIL);
    assign state_dbg        = state;
endmodule

// File: tb/tb_aib_link_bringup_seq.sv
// Bench for aib_link_bringup_seq: vector table, directed corner sequences, and randomized
// stimulus checked cycle by cycle against a bring-up timeline model plus an AVMM write scoreboard.
module tb_aib_link_bringup_seq;
    localparam int CFG_DEPTH   = 3;
    localparam int TIMEOUT_CYC = 100;
    localparam int SETTLE_CYC  = 16;
    localparam int MAX_RETRY   = 3;
    localparam int AVMM_WIDTH  = 32;
    localparam int BYTE_WIDTH  = 4;

    // ---------------- clock / reset / DUT ----------------
    logic clk_wr = 1'b0;
    always #5 clk_wr = ~clk_wr;

    logic                  rst_wr, start, m_device_detect;
    logic                  ms_tx_transfer_en, sl_tx_transfer_en, m_rx_align_done, fs_mac_rdy;
    logic [5:0]            cfg_idx;
    logic [16:0]           cfg_addr;
    logic [AVMM_WIDTH-1:0] cfg_wdata;
    logic                  ns_adapter_rstn, ns_mac_rdy, tx_online, rx_online, link_up, link_fail;
    logic [3:0]            dcc_dll_lock_req, state_dbg;
    logic [1:0]            retry_cnt;

    aib_link_bringup_seq_if #(.AVMM_WIDTH(AVMM_WIDTH), .BYTE_WIDTH(BYTE_WIDTH)) avmm_bus ();

    aib_link_bringup_seq #(
        .CFG_DEPTH(CFG_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC), .SETTLE_CYC(SETTLE_CYC),
        .MAX_RETRY(MAX_RETRY), .AVMM_WIDTH(AVMM_WIDTH), .BYTE_WIDTH(BYTE_WIDTH)
    ) dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr), .start(start), .m_device_detect(m_device_detect),
        .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .avmm(avmm_bus.master),
        .ns_adapter_rstn(ns_adapter_rstn), .ns_mac_rdy(ns_mac_rdy),
        .dcc_dll_lock_req(dcc_dll_lock_req), .ms_tx_transfer_en(ms_tx_transfer_en),
        .sl_tx_transfer_en(sl_tx_transfer_en), .m_rx_align_done(m_rx_align_done),
        .fs_mac_rdy(fs_mac_rdy), .tx_online(tx_online), .rx_online(rx_online),
        .link_up(link_up), .link_fail(link_fail), .retry_cnt(retry_cnt), .state_dbg(state_dbg)
    );

    // Config table ROM seen through cfg_idx
    logic [16:0]           tbl_addr [CFG_DEPTH];
    logic [AVMM_WIDTH-1:0] tbl_data [CFG_DEPTH];
    always_comb begin
        cfg_addr  = '0;
        cfg_wdata = '0;
        if (cfg_idx < 6'(CFG_DEPTH)) begin
            cfg_addr  = tbl_addr[cfg_idx[1:0]];
            cfg_wdata = tbl_data[cfg_idx[1:0]];
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int wr_accepts = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_OFF = 0, M_DET = 1, M_CFG = 2, M_SETTLE = 3, M_LOCK = 4,
                   M_UP = 5, M_RETRY = 6, M_FAIL = 7;
    int   m_mode = M_OFF;
    int   m_idx = 0, m_wait = 0, m_retries = 0;
    bit   m_wr = 0, m_online = 0;
    logic [16+AVMM_WIDTH:0] exp_q [$];

    task automatic model_issue();
        m_wr = 1'b1;
        exp_q.push_back({tbl_addr[m_idx], tbl_data[m_idx]});
    endtask

    task automatic model_step();
        logic ok4, det, wreq;
        ok4  = ms_tx_transfer_en & sl_tx_transfer_en & m_rx_align_done & fs_mac_rdy;
        det  = m_device_detect;
        wreq = avmm_bus.avmm_waitreq;
        if (rst_wr || (!start && m_mode != M_FAIL)) begin
            m_mode = M_OFF; m_wr = 0; m_idx = 0; m_wait = 0; m_online = 0; m_retries = 0;
            exp_q.delete();
        end else begin
            case (m_mode)
                M_OFF: m_mode = M_DET;
                M_DET: if (det) begin m_mode = M_CFG; m_idx = 0; model_issue(); end
                M_CFG: begin
                    if (m_wr) begin
                        if (!wreq) begin
                            m_wr = 0;
                            m_idx++;
                            if (!det) m_mode = M_RETRY;
                            else if (m_idx == CFG_DEPTH) begin m_mode = M_SETTLE; m_wait = 0; end
                        end
                    end else if (!det) m_mode = M_RETRY;
                    else model_issue();
                end
                M_SETTLE: begin
                    if (!det) m_mode = M_RETRY;
                    else if (m_wait == SETTLE_CYC - 1) begin m_mode = M_LOCK; m_wait = 0; end
                    else m_wait++;
                end
                M_LOCK: begin
                    if (!det) m_mode = M_RETRY;
                    else if (ok4) m_mode = M_UP;
                    else if (m_wait == TIMEOUT_CYC - 1) m_mode = M_RETRY;
                    else m_wait++;
                end
                M_UP: begin
                    if (!det || !ok4) begin m_mode = M_RETRY; m_online = 0; end
                    else m_online = 1;
                end
                M_RETRY: begin
                    m_idx = 0;
                    if (m_retries == MAX_RETRY) m_mode = M_FAIL;
                    else begin m_retries++; m_mode = M_DET; end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_model();
        logic e_rstn;
        logic [22:0] got, exp;
        e_rstn = (m_mode == M_SETTLE) || (m_mode == M_LOCK) || (m_mode == M_UP);
        got = {avmm_bus.avmm_write, avmm_bus.avmm_byte_en, cfg_idx, ns_adapter_rstn, ns_mac_rdy,
               dcc_dll_lock_req, tx_online, rx_online, link_up, link_fail, retry_cnt};
        exp = {m_wr, m_wr ? 4'hF : 4'h0, 6'(m_idx), e_rstn, e_rstn,
               (m_mode == M_LOCK || m_mode == M_UP) ? 4'hF : 4'h0,
               m_online, m_online, m_online, m_mode == M_FAIL, 2'(m_retries)};
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL model cycle %0d: got %h expected %h (state_dbg %0d)", cyc, got, exp, state_dbg);
        end
    endtask

    // Write scoreboard: an accepted write must match the next expected table entry.
    always @(negedge clk_wr) begin
        if (avmm_bus.avmm_write === 1'b1 && avmm_bus.avmm_waitreq === 1'b0) begin
            wr_accepts++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL avmm_unexpected: got addr %0h with no write expected", avmm_bus.avmm_addr);
            end else if ({avmm_bus.avmm_addr, avmm_bus.avmm_wdata} !== exp_q[0]) begin
                n_errors++;
                $display("FAIL avmm_write: got %0h expected %0h",
                         {avmm_bus.avmm_addr, avmm_bus.avmm_wdata}, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic s, input logic d, input logic w, input logic [3:0] ok);
        rst_wr = r; start = s; m_device_detect = d; avmm_bus.avmm_waitreq = w;
        {ms_tx_transfer_en, sl_tx_transfer_en, m_rx_align_done, fs_mac_rdy} = ok;
    endtask

    task automatic tick();
        @(posedge clk_wr);
        #1;
        cyc++;
        model_step();
        check_model();
    endtask

    typedef struct {
        logic       r, s, d, w;
        logic [3:0] ok;
        int         n;
        logic       e_wr;
        logic [5:0] e_idx;
        logic       e_rstn;
        logic [3:0] e_lreq;
        logic       e_up, e_fail;
        logic [1:0] e_rc;
    } vec_t;

    function automatic vec_t mk(logic r, logic s, logic d, logic w, logic [3:0] ok, int n,
                                logic e_wr, logic [5:0] e_idx, logic e_rstn, logic [3:0] e_lreq,
                                logic e_up, logic e_fail, logic [1:0] e_rc);
        vec_t v;
        v.r = r; v.s = s; v.d = d; v.w = w; v.ok = ok; v.n = n;
        v.e_wr = e_wr; v.e_idx = e_idx; v.e_rstn = e_rstn; v.e_lreq = e_lreq;
        v.e_up = e_up; v.e_fail = e_fail; v.e_rc = e_rc;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [18];
        int   seg_bad;
        for (int i = 0; i < CFG_DEPTH; i++) begin
            tbl_addr[i] = 17'($urandom);
            tbl_data[i] = $urandom;
        end
        drive(1, 0, 0, 0, 4'h0);

        // Nominal bring-up, link loss + retry, re-sequence, then start drop.
        vecs[0]  = mk(1, 0, 0, 0, 4'h0, 2,  0, 0, 0, 4'h0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 4'h0, 1,  0, 0, 0, 4'h0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 4'h0, 3,  0, 0, 0, 4'h0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 1, 0, 4'h0, 1,  1, 0, 0, 4'h0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 1, 0, 4'h0, 1,  0, 1, 0, 4'h0, 0, 0, 0);
        vecs[5]  = mk(0, 1, 1, 0, 4'h0, 1,  1, 1, 0, 4'h0, 0, 0, 0);
        vecs[6]  = mk(0, 1, 1, 0, 4'h0, 2,  1, 2, 0, 4'h0, 0, 0, 0);
        vecs[7]  = mk(0, 1, 1, 0, 4'h0, 1,  0, 3, 1, 4'h0, 0, 0, 0);
        vecs[8]  = mk(0, 1, 1, 0, 4'h0, 15, 0, 3, 1, 4'h0, 0, 0, 0);
        vecs[9]  = mk(0, 1, 1, 0, 4'h0, 1,  0, 3, 1, 4'hF, 0, 0, 0);
        vecs[10] = mk(0, 1, 1, 0, 4'hF, 1,  0, 3, 1, 4'hF, 0, 0, 0);
        vecs[11] = mk(0, 1, 1, 0, 4'hF, 1,  0, 3, 1, 4'hF, 1, 0, 0);
        vecs[12] = mk(0, 1, 1, 0, 4'hF, 5,  0, 3, 1, 4'hF, 1, 0, 0);
        vecs[13] = mk(0, 1, 1, 0, 4'hE, 1,  0, 3, 0, 4'h0, 0, 0, 0);
        vecs[14] = mk(0, 1, 1, 0, 4'hF, 1,  0, 0, 0, 4'h0, 0, 0, 1);
        vecs[15] = mk(0, 1, 1, 0, 4'hF, 1,  1, 0, 0, 4'h0, 0, 0, 1);
        vecs[16] = mk(0, 1, 1, 0, 4'hF, 23, 0, 3, 1, 4'hF, 1, 0, 1);
        vecs[17] = mk(0, 0, 1, 0, 4'hF, 1,  0, 0, 0, 4'h0, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].r, vecs[i].s, vecs[i].d, vecs[i].w, vecs[i].ok);
            repeat (vecs[i].n) tick();
            check($sformatf("vec_%0d", i),
                  {avmm_bus.avmm_write, cfg_idx, ns_adapter_rstn, dcc_dll_lock_req,
                   link_up, tx_online, link_fail, retry_cnt},
                  {vecs[i].e_wr, vecs[i].e_idx, vecs[i].e_rstn, vecs[i].e_lreq,
                   vecs[i].e_up, vecs[i].e_up, vecs[i].e_fail, vecs[i].e_rc});
        end

        // Wait request held on write 1: outputs frozen, index does not advance.
        drive(0, 1, 1, 0, 4'h0);
        repeat (4) tick();
        check("hold_entry", {avmm_bus.avmm_write, cfg_idx, avmm_bus.avmm_addr, avmm_bus.avmm_wdata},
              {1'b1, 6'd1, tbl_addr[1], tbl_data[1]});
        avmm_bus.avmm_waitreq = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("hold_%0d", k),
                  {avmm_bus.avmm_write, cfg_idx, avmm_bus.avmm_addr, avmm_bus.avmm_wdata},
                  {1'b1, 6'd1, tbl_addr[1], tbl_data[1]});
        end
        avmm_bus.avmm_waitreq = 1'b0;
        tick();
        check("hold_release", {avmm_bus.avmm_write, cfg_idx}, {1'b0, 6'd2});

        // Reset while a write is stalled.
        avmm_bus.avmm_waitreq = 1'b1;
        repeat (2) tick();
        rst_wr = 1'b1;
        tick();
        check("rst_abort", {avmm_bus.avmm_write, ns_adapter_rstn, cfg_idx}, {1'b0, 1'b0, 6'd0});
        drive(0, 1, 1, 0, 4'h0);
        repeat (2) tick();
        check("restart_idx0", {avmm_bus.avmm_write, cfg_idx, avmm_bus.avmm_addr},
              {1'b1, 6'd0, tbl_addr[0]});

        // Alignment never completes: retries exhaust into sticky failure.
        wr_accepts = 0;
        drive(0, 1, 1, 0, 4'b1101);
        for (int k = 0; k < 3000 && link_fail !== 1'b1; k++) tick();
        check("fail_reached", link_fail, 1'b1);
        check("fail_retry_cnt", retry_cnt, 2'd3);
        check("fail_cfg_runs", wr_accepts, 4 * CFG_DEPTH);
        start = 1'b0;
        repeat (5) tick();
        check("fail_sticky", {link_fail, retry_cnt, ns_adapter_rstn, dcc_dll_lock_req, link_up},
              {1'b1, 2'd3, 1'b0, 4'h0, 1'b0});
        rst_wr = 1'b1;
        tick();
        check("fail_cleared", {link_fail, retry_cnt}, 3'b000);

        // Randomized soak against the model.
        seg_bad = 0;
        for (int k = 0; k < 4000; k++) begin
            if (k % 300 == 0) seg_bad = $urandom_range(0, 2);
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 499) != 0,
                  $urandom_range(0, 299) != 0,
                  $urandom_range(0, 2) == 0,
                  ($urandom_range(0, 99) < 97) ? ((seg_bad == 0) ? 4'b1101 : 4'hF)
                                               : 4'($urandom_range(0, 15)));
            tick();
        end
        drive(1, 0, 0, 0, 4'h0);
        tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
